// File: rtl/sync_tx_sched.sv
// Round-robin scheduler that time-shares one synchronizer chain input between NREQ requesters.
// Each transfer holds ODATA with OVALID high for HOLD cycles, then spends one GAP cycle pulsing ACK.
module sync_tx_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int HOLD = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] REQ_DATA,
  output logic [NREQ-1:0]   ACK,
  output logic [W-1:0]      ODATA,
  output logic              OVALID,
  output logic [1:0]        OSRC,
  output logic              BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [1:0]          last;
  logic [3:0]          req_pad;
  logic [3:0][W-1:0]   data_pad;
  logic [3:0]          ack_pad;
  logic                gnt_vld;
  logic [1:0]          gnt_idx;

  // Pad to the 4-requester maximum so every select uses a plain 2-bit index.
  always_comb begin
    req_pad  = 4'(REQ);
    data_pad = '0;
    for (int i = 0; i < NREQ; i++) data_pad[i] = REQ_DATA[i*W +: W];
  end

  // Search upward from last+1 with wrap; the previous grantee is examined last.
  always_comb begin
    logic [2:0] s;
    gnt_vld = 1'b0;
    gnt_idx = last;
    for (int j = 1; j <= NREQ; j++) begin
      s = {1'b0, last} + 3'(j);
      if (s >= 3'(NREQ)) s = s - 3'(NREQ);
      if (!gnt_vld && req_pad[s[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = s[1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_vld)    state_nxt = S_HOLD;
      S_HOLD:  if (cnt == '0)  state_nxt = S_GAP;
      S_GAP:                   state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // ODATA/OSRC load only on a grant, so they stay frozen through HOLD, GAP and IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      last  <= 2'(NREQ-1);
      ODATA <= '0;
      OSRC  <= '0;
    end else if (state == S_IDLE && gnt_vld) begin
      cnt   <= 4'(HOLD-1);
      last  <= gnt_idx;
      ODATA <= data_pad[gnt_idx];
      OSRC  <= gnt_idx;
    end else if (state == S_HOLD && cnt != '0) begin
      cnt   <= cnt - 4'd1;
    end
  end

  always_comb begin
    ack_pad = '0;
    if (state == S_GAP) ack_pad[OSRC] = 1'b1;
    ACK    = ack_pad[NREQ-1:0];
    OVALID = (state == S_HOLD);
    BUSY   = (state != S_IDLE);
  end

endmodule

// File: tb/tb_sync_tx_sched.sv
// Bench for sync_tx_sched: two instances (HOLD=3 and HOLD=1) on shared stimulus, each checked
// every cycle against a transaction-timing model plus directed ACK-order checks.
module tb_sync_tx_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = '0;
  logic [15:0] REQ_DATA = '0;

  logic [3:0] ack0, ack1;
  logic [3:0] odata0, odata1;
  logic       ovalid0, ovalid1, busy0, busy1;
  logic [1:0] osrc0, osrc1;

  always #5 CLK = ~CLK;

  sync_tx_sched #(.NREQ(4), .W(4), .HOLD(3)) dut3 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA),
    .ACK(ack0), .ODATA(odata0), .OVALID(ovalid0), .OSRC(osrc0), .BUSY(busy0));

  sync_tx_sched #(.NREQ(4), .W(4), .HOLD(1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA),
    .ACK(ack1), .ODATA(odata1), .OVALID(ovalid1), .OSRC(osrc1), .BUSY(busy1));

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;

  // Model: a transfer granted at cycle g is valid g+1..g+H, acks at g+H+1, frees at g+H+2.
  int         hh[2] = '{3, 1};
  bit         m_act[2];
  int         m_g[2];
  int         m_last[2];
  logic [3:0] m_d[2];
  logic [1:0] m_s[2];

  int q0_idx[$], q0_cyc[$], q1_idx[$], q1_cyc[$];

  function automatic bit e_vld(int k);
    return m_act[k] && cyc >= m_g[k] + 1 && cyc <= m_g[k] + hh[k];
  endfunction
  function automatic bit e_busy(int k);
    return m_act[k] && cyc >= m_g[k] + 1 && cyc <= m_g[k] + hh[k] + 1;
  endfunction
  function automatic logic [3:0] e_ack(int k);
    if (m_act[k] && cyc == m_g[k] + hh[k] + 1) return 4'b0001 << m_s[k];
    return 4'b0000;
  endfunction
  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_upd(input int k, input bit r, input logic [3:0] rq, input logic [15:0] d);
    int idx;
    if (r) begin
      m_act[k] = 0; m_last[k] = 3; m_d[k] = '0; m_s[k] = '0;
    end else if ((!m_act[k] || cyc >= m_g[k] + hh[k] + 2) && rq != 0) begin
      idx = -1;
      for (int j = 1; j <= 4 && idx < 0; j++)
        if (rq[(m_last[k] + j) % 4]) idx = (m_last[k] + j) % 4;
      m_act[k] = 1; m_g[k] = cyc; m_last[k] = idx;
      m_d[k] = 4'(d >> (idx*4)); m_s[k] = 2'(idx);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input logic [3:0] rq, input logic [15:0] d, input bit en);
    @(negedge CLK);
    RST = r; REQ = rq; REQ_DATA = d;
    if (en) begin
      chk("h3_ack", ack0, e_ack(0));    chk("h1_ack", ack1, e_ack(1));
      chk("h3_ovalid", ovalid0, e_vld(0)); chk("h1_ovalid", ovalid1, e_vld(1));
      chk("h3_busy", busy0, e_busy(0)); chk("h1_busy", busy1, e_busy(1));
      chk("h3_odata", odata0, m_d[0]);  chk("h1_odata", odata1, m_d[1]);
      chk("h3_osrc", osrc0, m_s[0]);    chk("h1_osrc", osrc1, m_s[1]);
      if (ack0 != 0) begin q0_idx.push_back(oh2i(ack0)); q0_cyc.push_back(cyc); end
      if (ack1 != 0) begin q1_idx.push_back(oh2i(ack1)); q1_cyc.push_back(cyc); end
    end
    model_upd(0, r, rq, d);
    model_upd(1, r, rq, d);
    cyc++;
  endtask

  task automatic clr_logs();
    q0_idx.delete(); q0_cyc.delete(); q1_idx.delete(); q1_cyc.delete();
  endtask

  initial begin
    int t;
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};

    step(1, 4'b1111, 16'hFFFF, 0);
    step(1, 4'b1111, 16'hFFFF, 1);       // reset state and REQ ignored during reset

    // single request, data 0xA on requester 0
    clr_logs(); t = cyc;
    step(0, 4'b0001, {12'($urandom), 4'hA}, 1);
    repeat (6) step(0, 4'b0000, 16'($urandom), 1);
    chk("single_ack_n", q0_cyc.size(), 1);
    if (q0_cyc.size() >= 1) begin
      chk("single_ack_cyc", q0_cyc[0], t + 4);
      chk("single_ack_idx", q0_idx[0], 0);
    end

    // all four requesting constantly after reset
    step(1, 4'b1111, 16'($urandom), 1);
    clr_logs(); t = cyc;
    repeat (28) step(0, 4'b1111, 16'($urandom), 1);
    chk("rr_ack_n", q0_idx.size() >= 5, 1);
    if (q0_idx.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", q0_idx[i], exp_rr[i]);
        if (i > 0) chk("rr_spacing", q0_cyc[i] - q0_cyc[i-1], 5);
      end

    // grantee drops REQ and changes data mid-transfer
    step(1, 4'b0000, 16'h0000, 1);
    clr_logs(); t = cyc;
    step(0, 4'b0100, 16'h0500, 1);
    step(0, 4'b0000, 16'h0F00, 1);
    step(0, 4'b0000, 16'h0C00, 1);
    repeat (4) step(0, 4'b0000, 16'($urandom), 1);
    chk("drop_ack_n", q0_cyc.size(), 1);
    if (q0_cyc.size() >= 1) begin
      chk("drop_ack_cyc", q0_cyc[0], t + 4);
      chk("drop_ack_idx", q0_idx[0], 2);
    end

    // reset two cycles into a transfer, then all requesting
    step(1, 4'b0000, 16'h0000, 1);
    step(0, 4'b1000, 16'h7000, 1);
    repeat (6) step(0, 4'b0000, 16'($urandom), 1);
    clr_logs(); t = cyc;
    step(0, 4'b0010, 16'h0090, 1);
    step(0, 4'b0000, 16'($urandom), 1);
    step(1, 4'b1111, 16'($urandom), 1);
    repeat (8) step(0, 4'b1111, 16'($urandom), 1);
    chk("rst_first_ack_idx", (q0_idx.size() > 0) ? q0_idx[0] : -1, 0);
    chk("rst_first_ack_cyc", (q0_cyc.size() > 0) ? q0_cyc[0] : -1, t + 3 + 4);

    // HOLD=1 instance: single OVALID cycle and re-grant at t+3
    step(1, 4'b0000, 16'h0000, 1);
    clr_logs(); t = cyc;
    step(0, 4'b0100, 16'h0300, 1);
    step(0, 4'b0000, 16'($urandom), 1);
    step(0, 4'b0000, 16'($urandom), 1);
    step(0, 4'b0100, 16'h0600, 1);
    repeat (5) step(0, 4'b0000, 16'($urandom), 1);
    chk("h1_ack_n", q1_cyc.size(), 2);
    if (q1_cyc.size() >= 2) begin
      chk("h1_ack_cyc0", q1_cyc[0], t + 2);
      chk("h1_ack_cyc1", q1_cyc[1], t + 5);
      chk("h1_ack_idx", q1_idx[1], 2);
    end

    // two persistent requesters alternate
    step(1, 4'b0000, 16'h0000, 1);
    clr_logs();
    repeat (24) step(0, 4'b0011, 16'($urandom), 1);
    chk("alt_ack_n", q0_idx.size() >= 4, 1);
    if (q0_idx.size() >= 4)
      for (int i = 0; i < 4; i++) chk("alt_order", q0_idx[i], i % 2);

    // random traffic with occasional reset
    step(1, 4'b0000, 16'h0000, 1);
    repeat (300)
      step($urandom_range(0, 39) == 0, 4'($urandom), 16'($urandom), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/sync_tx_sched.md
SYNC_TX_SCHED -- requirements
Module: sync_tx_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the synchronizer chain (legal range 2..4).
REQ-002 The block SHALL have parameter W, default 4, meaning the data width driven into the synchronizer chain.
REQ-003 The block SHALL have parameter HOLD, default 3, meaning the number of cycles ODATA is presented with OVALID high (legal range 1..15).
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all logic is in this domain.
REQ-005 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port REQ, input, NREQ, per-requester transfer request (level).
REQ-007 The block SHALL have port REQ_DATA, input, NREQ*W, requester i's data in bits [i*W +: W].
REQ-008 The block SHALL have port ACK, output, NREQ, one-cycle completion pulse to the served requester.
REQ-009 The block SHALL have port ODATA, output, W, registered data driven into the synchronizer chain input.
REQ-010 The block SHALL have port OVALID, output, 1, high while ODATA is in its hold window.
REQ-011 The block SHALL have port OSRC, output, 2, index of the requester currently or last served.
REQ-012 The block SHALL have port BUSY, output, 1, high in any state other than IDLE.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, HOLD and GAP.
REQ-014 In IDLE with any REQ bit high, the block SHALL grant one requester by round-robin, searching upward (with wrap) from last-granted index + 1.
REQ-015 On grant in cycle t, the block SHALL, at cycle t+1, register ODATA = REQ_DATA of the grantee, OSRC = grantee index, OVALID = 1, and enter HOLD.
REQ-016 OVALID SHALL stay high for exactly HOLD consecutive cycles (t+1 .. t+HOLD), with ODATA and OSRC constant.
REQ-017 After the last HOLD cycle, the block SHALL enter GAP for exactly one cycle (t+HOLD+1) with OVALID = 0 and ACK[grantee] = 1; all other ACK bits SHALL be 0.
REQ-018 ODATA and OSRC SHALL remain unchanged through GAP and IDLE until the next grant; no glitch or partial update of ODATA is permitted.
REQ-019 From GAP, the block SHALL return to IDLE at t+HOLD+2 and may grant in that same cycle; minimum transfer period is HOLD+2 cycles.
REQ-020 REQ SHALL be sampled only in IDLE; REQ changes during HOLD or GAP SHALL be ignored.
REQ-021 A transfer in progress SHALL always complete with its ACK, even if the grantee's REQ drops mid-transfer.
REQ-022 REQ_DATA SHALL be captured only at the grant cycle; later changes SHALL not affect ODATA.
REQ-023 A requester still holding REQ high in the cycle after its ACK SHALL be treated as a new request with lowest round-robin priority.
REQ-024 With all REQ low in IDLE, the block SHALL stay in IDLE, with OVALID = 0 and ACK = 0.
REQ-025 The hold counter SHALL be 4 bits wide and count down from HOLD-1 to 0; HOLD = 1 SHALL give a single OVALID cycle.

Reset
REQ-026 When RST is high at a CLK edge, the block SHALL set the state to IDLE, ODATA = 0, OVALID = 0, ACK = 0, OSRC = 0 and BUSY = 0, and set the last-granted pointer to NREQ-1 so requester 0 has first priority.
REQ-027 Reset asserted during HOLD or GAP SHALL abort the transfer without issuing ACK.
REQ-028 REQ SHALL be ignored in the reset cycle, and arbitration SHALL resume in the first cycle after RST deasserts.

Verification
REQ-029 The bench SHALL cover single request: with HOLD=3 and REQ=0001, REQ_DATA[3:0]=0xA at t -> ODATA=0xA, OVALID=1 at t+1..t+3, ACK=0001 at t+4, BUSY=0 at t+5.
REQ-030 The bench SHALL cover round-robin with all requesters active: REQ=1111 held constantly after reset -> grant order 0,1,2,3,0, with ACKs spaced 5 cycles apart.
REQ-031 The bench SHALL cover mid-transfer drop and data change: REQ[2] deasserted and REQ_DATA[2] changed during HOLD -> ODATA holds the captured value and ACK[2] still pulses at t+HOLD+1.
REQ-032 The bench SHALL cover reset mid-HOLD: RST=1 at t+2 -> no ACK, and ODATA=0, OVALID=0, OSRC=0 next cycle; the next grant goes to requester 0 when REQ=1111.
REQ-033 The bench SHALL cover HOLD=1: REQ=0100 at t -> OVALID high only at t+1, ACK=0100 at t+2, and a re-grant is possible at t+3.
REQ-034 The bench SHALL cover persistent requester: REQ=0011 constant -> alternating grants 0,1,0,1, and requester 0 never served twice in a row.
